cnt_bank: RTL
=============

# cnt_bank

Responder end of the `cnt_req`/`cnt_addr`/`cnt_data`/`cnt_ack` request channel driven by the AXI-lite-to-cnt bridge in the core clock domain. Holds a bank of 64-bit event counters plus sticky assertion-failure flags, and answers 32-bit read requests with a four-phase handshake. It raises a sticky `assertion_failed` summary for the SoC. It replaces ad-hoc counter logic behind the bridge with one decoded, coherent-read register file.

## Interface
- NUM_CNT, 8, number of 64-bit event counters (1..16)
- NUM_ASSERT, 8, number of assertion inputs (1..31)
- clock  in  1  core clock; single clock domain
- reset  in  1  synchronous, active-high reset
- cnt_req  in  1  request level from bridge; held high until `cnt_ack` seen
- cnt_addr  in  32  byte address; bits [1:0] ignored, bits [31:9] ignored
- cnt_data  out  32  read data; valid while `cnt_ack`=1
- cnt_ack  out  1  response level; high until `cnt_req` drops
- event_i  in  NUM_CNT  per-counter increment strobe, one increment per high cycle
- assert_i  in  NUM_ASSERT  assertion-fail strobes, active-high
- assertion_failed  out  1  OR of all sticky assertion flags

## Operation
- Address map (offset = cnt_addr[8:0]):
  - 0x000 + 8*i: counter i low word; read also latches counter i high word into the shared shadow register.
  - 0x004 + 8*i: returns the shadow (high word of last low-read), not live counter.
  - 0x100: sticky assertion flags, bit k = assert_i[k] seen; upper bits 0.
  - 0x104: first-fail record {bit31 valid, bits[4:0] index}.
  - 0x108: NUM_CNT in [7:0], NUM_ASSERT in [15:8].
  - Any other offset, or i >= NUM_CNT: 0xDEAD_BEEF.
- Counters: increment by 1 per `event_i[i]` cycle; wrap 2^64-1 -> 0; no saturation.
- Sticky flags set on `assert_i[k]`=1, cleared only by reset (or clear register, see Configuration).
- First-fail: records the lowest index asserted in the first cycle any flag sets while valid=0; afterwards frozen.
- FSM states IDLE, LOOKUP, ACK:
  - IDLE: `cnt_req`=1 -> register address -> LOOKUP.
  - LOOKUP: mux register data into `cnt_data`, perform side effects (shadow latch, clear) -> ACK.
  - ACK: `cnt_ack`=1; stay until `cnt_req`=0 -> IDLE (ack drops same edge).
- Address is sampled only on IDLE->LOOKUP; changes of `cnt_addr` later are ignored.

## Timing
- Reset: `cnt_ack`=0, `cnt_data`=0, `assertion_failed`=0, counters/shadow/flags/first-fail = 0, FSM = IDLE.
- Latency: `cnt_req` sampled high at edge N -> `cnt_ack` high after edge N+2; `cnt_data` stable from that cycle until the next LOOKUP.
- Minimum request period: 4 cycles (IDLE, LOOKUP, ACK, req-low observed).
- Event and read of same counter in LOOKUP cycle: data/shadow capture pre-increment value; increment is not lost.
- `assert_i` and read of 0x100 same cycle: returned value excludes the new bit; flag still sets.
- `assertion_failed` registered: rises one cycle after the first `assert_i` pulse.
- `cnt_req` dropping before ack (protocol violation): FSM completes to ACK, ack lasts one cycle, returns to IDLE.
- Reset mid-transaction: FSM to IDLE, ack drops next edge, all state cleared.

## Configuration
- `CNT_BANK_CLEAR_EN` defined: offset 0x110 is read-to-clear; returns 0x0000_0000, and in LOOKUP clears all counters, shadow, sticky flags and first-fail; events in that same cycle are dropped; `assertion_failed` falls next cycle.
- Not defined: 0x110 is unmapped (0xDEAD_BEEF), no clear path exists; state only cleared by `reset`.

## Structure
- Package `cnt_bank_pkg`: FSM state enum, offset constants (CNT_BASE, ASSERT_STICKY, FIRST_FAIL, INFO, CLEAR), UNMAPPED_DATA = 32'hDEAD_BEEF.
- Sub-module `cnt_bank_counter`: one 64-bit wrapping counter with `inc`, `clr` inputs; instantiated NUM_CNT times. Top holds FSM, decode, shadow, assertion logic.

## Test plan
- Reset, then read 0x108 -> `cnt_ack` 2 cycles after req, data 0x0000_0808; read 0x1F0 -> 0xDEAD_BEEF.
- Pulse `event_i[3]` 5 cycles, read 0x018 then 0x01C -> 0x0000_0005, 0x0000_0000.
- Force counter 0 to 0xFFFF_FFFF_FFFF_FFFF via preload, one event -> low/high read 0, 0 (wrap).
- Read 0x000 with `event_i[0]` in LOOKUP cycle at count 0x0000_0000_FFFF_FFFF -> low 0xFFFF_FFFF, high 0x0000_0000; subsequent read low 0x0000_0000, high 0x0000_0001.
- `assert_i`=0x28 in one cycle -> `assertion_failed`=1 next cycle; 0x100 -> 0x28; 0x104 -> 0x8000_0003; later `assert_i[0]` leaves 0x104 unchanged.
- With `CNT_BANK_CLEAR_EN`: read 0x110 -> 0x0, then 0x100 -> 0, `assertion_failed`=0; without it -> 0xDEAD_BEEF, flags retained.

Source files
------------

// File: rtl/cnt_bank_pkg.sv
// rtl/cnt_bank_pkg.sv - shared types and register offsets for the counter bank
package cnt_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  localparam logic [8:0]  CNT_BASE      = 9'h000;
  localparam logic [8:0]  ASSERT_STICKY = 9'h100;
  localparam logic [8:0]  FIRST_FAIL    = 9'h104;
  localparam logic [8:0]  INFO          = 9'h108;
  localparam logic [8:0]  CLEAR         = 9'h110;
  localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/cnt_bank_counter.sv
// rtl/cnt_bank_counter.sv - one 64-bit wrapping event counter
// Clear takes priority so an event in the clearing cycle is dropped.
module cnt_bank_counter
  import cnt_bank_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  input  logic        clr,
  output logic [63:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/cnt_bank.sv
// rtl/cnt_bank.sv - counter bank responder with sticky assertion flags
// Optional read-to-clear register at offset 0x110 enabled by CNT_BANK_CLEAR_EN.
module cnt_bank
  import cnt_bank_pkg::*;
#(
  parameter int NUM_CNT    = 8,
  parameter int NUM_ASSERT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cnt_req,
  input  logic [31:0]           cnt_addr,
  output logic [31:0]           cnt_data,
  output logic                  cnt_ack,
  input  logic [NUM_CNT-1:0]    event_i,
  input  logic [NUM_ASSERT-1:0] assert_i,
  output logic                  assertion_failed
);

  state_t                state;
  logic [6:0]            wa;
  logic [6:0]            cnt_word;
  logic [63:0]           cnt_val [NUM_CNT];
  logic [63:0]           sel_cnt;
  logic [31:0]           shadow;
  logic [31:0]           rd_data;
  logic [NUM_ASSERT-1:0] flags;
  logic                  ff_valid;
  logic [4:0]            ff_idx;
  logic [4:0]            low_idx;
  logic                  lookup;
  logic                  is_clear;
  logic                  latch_shadow;
  logic                  clr_all;
  logic                  unused_bits;

  assign lookup   = (state == ST_LOOKUP);
  assign cnt_word = wa - CNT_BASE[8:2];
  assign is_clear = (wa == CLEAR[8:2]);

`ifdef CNT_BANK_CLEAR_EN
  assign clr_all = lookup & is_clear;
`else
  assign clr_all = 1'b0;
`endif

  assign unused_bits = ^{cnt_addr[31:9], cnt_addr[1:0], cnt_word[6], is_clear};

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    cnt_bank_counter u_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (event_i[i]),
      .clr   (clr_all),
      .count (cnt_val[i])
    );
  end

  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (cnt_word[5:1] == i[4:0]) sel_cnt = cnt_val[i];
    end
  end

  // Counters sit at two words each: even word is live low half, odd word is the shadow.
  always_comb begin
    rd_data      = UNMAPPED_DATA;
    latch_shadow = 1'b0;
    if (wa < ASSERT_STICKY[8:2]) begin
      if ({27'd0, cnt_word[5:1]} < NUM_CNT) begin
        if (cnt_word[0]) begin
          rd_data = shadow;
        end else begin
          rd_data      = sel_cnt[31:0];
          latch_shadow = 1'b1;
        end
      end
    end else if (wa == ASSERT_STICKY[8:2]) begin
      rd_data = 32'(flags);
    end else if (wa == FIRST_FAIL[8:2]) begin
      rd_data = {ff_valid, 26'd0, ff_idx};
    end else if (wa == INFO[8:2]) begin
      rd_data = {16'd0, 8'(NUM_ASSERT), 8'(NUM_CNT)};
`ifdef CNT_BANK_CLEAR_EN
    end else if (is_clear) begin
      rd_data = 32'd0;
`endif
    end
  end

  always_comb begin
    low_idx = '0;
    for (int k = NUM_ASSERT - 1; k >= 0; k--) begin
      if (assert_i[k]) low_idx = k[4:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clr_all) begin
      shadow           <= '0;
      flags            <= '0;
      ff_valid         <= 1'b0;
      ff_idx           <= '0;
      assertion_failed <= 1'b0;
    end else begin
      if (lookup && latch_shadow) shadow <= sel_cnt[63:32];
      flags <= flags | assert_i;
      if (!ff_valid && (|assert_i)) begin
        ff_valid <= 1'b1;
        ff_idx   <= low_idx;
      end
      assertion_failed <= |(flags | assert_i);
    end
  end

  // Ack is raised one cycle into ACK and held until the request level drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      wa       <= '0;
      cnt_data <= '0;
      cnt_ack  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cnt_req) begin
            wa    <= cnt_addr[8:2];
            state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          cnt_data <= rd_data;
          state    <= ST_ACK;
        end
        ST_ACK: begin
          if (!cnt_ack) begin
            cnt_ack <= 1'b1;
          end else if (!cnt_req) begin
            cnt_ack <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
